// File: rtl/operand_addr_reg.sv
// Registered operand-address unit: direct, PC-relative, post-increment and (optional) memory-indirect modes.
// Define OPERAND_ADDR_INDIRECT_EN to build the indirect mode and its FETCH state; otherwise mode 10 acts as direct.
module operand_addr_reg #(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               post_inc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic               mem_rvalid,
  input  logic [ADDR_W-1:0]  mem_rdata,
  output logic [ADDR_W-1:0]  address,
  output logic               addr_valid
);

  localparam logic [1:0] MODE_REL = 2'b01;
  localparam logic [1:0] MODE_IND = 2'b10;
  localparam logic [1:0] MODE_INC = 2'b11;

  logic [ADDR_W-1:0] field;
  logic [ADDR_W-1:0] address_nxt;
  logic              addr_valid_nxt;
  logic              inc_armed;
  logic              inc_armed_nxt;

  assign field = instruction[ADDR_W-1:0];

  // Upper instruction bits carry opcode information that this unit does not decode.
`ifdef OPERAND_ADDR_INDIRECT_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, instruction};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, instruction, mem_rvalid, mem_rdata};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address    <= '0;
      addr_valid <= 1'b0;
      inc_armed  <= 1'b0;
    end else begin
      address    <= address_nxt;
      addr_valid <= addr_valid_nxt;
      inc_armed  <= inc_armed_nxt;
    end
  end

`ifdef OPERAND_ADDR_INDIRECT_EN
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              load_ready_nxt;
  logic              mem_req_nxt;
  logic [ADDR_W-1:0] mem_raddr_nxt;

  // Reset drops mem_req asynchronously so an in-flight read is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      mem_req    <= 1'b0;
      mem_raddr  <= '0;
    end else begin
      state      <= state_nxt;
      load_ready <= load_ready_nxt;
      mem_req    <= mem_req_nxt;
      mem_raddr  <= mem_raddr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_ready_nxt = load_ready;
    mem_req_nxt    = mem_req;
    mem_raddr_nxt  = mem_raddr;
    address_nxt    = address;
    addr_valid_nxt = addr_valid;
    inc_armed_nxt  = inc_armed;
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          inc_armed_nxt = (mode == MODE_INC);
          case (mode)
            MODE_REL: begin
              address_nxt    = pc + field;
              addr_valid_nxt = 1'b1;
            end
            MODE_IND: begin
              addr_valid_nxt = 1'b0;
              mem_raddr_nxt  = field;
              mem_req_nxt    = 1'b1;
              load_ready_nxt = 1'b0;
              state_nxt      = FETCH;
            end
            default: begin
              address_nxt    = field;
              addr_valid_nxt = 1'b1;
            end
          endcase
        end else if (post_inc && inc_armed && addr_valid) begin
          address_nxt = address + ADDR_W'(1);
        end
      end
      FETCH: begin
        if (mem_rvalid) begin
          address_nxt    = mem_rdata;
          addr_valid_nxt = 1'b1;
          mem_req_nxt    = 1'b0;
          load_ready_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign load_ready = 1'b1;
  assign mem_req    = 1'b0;
  assign mem_raddr  = '0;

  // Without the indirect path every accepted load resolves in one cycle.
  always_comb begin
    address_nxt    = address;
    addr_valid_nxt = addr_valid;
    inc_armed_nxt  = inc_armed;
    if (load_valid) begin
      inc_armed_nxt  = (mode == MODE_INC);
      addr_valid_nxt = 1'b1;
      if (mode == MODE_REL) begin
        address_nxt = pc + field;
      end else begin
        address_nxt = field;
      end
    end else if (post_inc && inc_armed && addr_valid) begin
      address_nxt = address + ADDR_W'(1);
    end
  end
`endif

endmodule
